// File: rtl/clk_gate_pkg.sv
// Shared types and default constants for the FIFO/ALU clock-gating controller.
package clk_gate_pkg;

  // Encoding matches the gate_state output.
  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StDrain = 2'b01,
    StGated = 2'b10,
    StWake  = 2'b11
  } gate_state_e;

  localparam int unsigned IDLE_THRESH_DEF = 4;
  localparam int unsigned WAKE_HOLD_DEF   = 2;
  localparam int unsigned CNT_W_DEF       = 16;

  localparam int unsigned IDLE_CNT_W = 8;
  localparam int unsigned WAKE_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter with enable that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock gate controller for the instruction-FIFO/ALU block: gates after a run of
// idle cycles, wakes on raw requests and stalls requesters until the clock is stable again.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned IDLE_THRESH = IDLE_THRESH_DEF,
  parameter int unsigned WAKE_HOLD   = WAKE_HOLD_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  input  logic             i_data_empty,
  input  logic             i_data_full,
  input  logic             i_force_on,
  output logic             o_fifo_wr_en,
  output logic             o_fifo_rd_en,
  output logic             o_clock_disable,
  output logic             o_stall,
  output logic [1:0]       o_gate_state,
  output logic [CNT_W-1:0] o_gated_cycles
);

  localparam logic [IDLE_CNT_W-1:0] IdleLast = IDLE_CNT_W'(IDLE_THRESH - 1);
  localparam logic [WAKE_CNT_W-1:0] WakeLast = WAKE_CNT_W'(WAKE_HOLD - 1);

  gate_state_e           r_state, w_state_d;
  logic [IDLE_CNT_W-1:0] r_idle_cnt, w_idle_cnt_d;
  logic [WAKE_CNT_W-1:0] r_wake_cnt, w_wake_cnt_d;
  logic                  w_act;
  logic                  w_wake_req;
  logic                  w_stall;

  // Requests blocked by FIFO status do no useful work, so they count as idle.
  assign w_act = (i_wr_en & ~i_data_full) | (i_rd_en & ~i_data_empty) | i_force_on;
  // FIFO flags are stale while gated, so wake on the raw requests.
  assign w_wake_req = i_wr_en | i_rd_en | i_force_on;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= StRun;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_idle_cnt <= w_idle_cnt_d;
      r_wake_cnt <= w_wake_cnt_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_idle_cnt_d = r_idle_cnt;
    w_wake_cnt_d = r_wake_cnt;
    unique case (r_state)
      StRun: begin
        if (w_act) begin
          w_idle_cnt_d = '0;
        end else begin
          w_state_d    = StDrain;
          w_idle_cnt_d = IDLE_CNT_W'(1);
        end
      end
      StDrain: begin
        if (w_act) begin
          w_state_d    = StRun;
          w_idle_cnt_d = '0;
        end else if (r_idle_cnt == IdleLast) begin
          w_state_d    = StGated;
          w_idle_cnt_d = '0;
        end else begin
          w_idle_cnt_d = r_idle_cnt + 1'b1;
        end
      end
      StGated: begin
        if (w_wake_req) begin
          w_state_d    = StWake;
          w_wake_cnt_d = '0;
        end
      end
      StWake: begin
        // Idle detection and force_on are ignored until the hold completes.
        if (r_wake_cnt == WakeLast) begin
          w_state_d    = StRun;
          w_wake_cnt_d = '0;
        end else begin
          w_wake_cnt_d = r_wake_cnt + 1'b1;
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  assign w_stall         = (r_state == StGated) | (r_state == StWake);
  assign o_stall         = w_stall;
  assign o_clock_disable = (r_state == StGated);
  assign o_gate_state    = r_state;
  assign o_fifo_wr_en    = i_wr_en & ~w_stall & ~i_data_full;
  assign o_fifo_rd_en    = i_rd_en & ~w_stall & ~i_data_empty;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_gated_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (r_state == StGated),
    .o_count (o_gated_cycles)
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios plus random traffic against an idle-run model.
module tb_clk_gate_ctrl;

  localparam int unsigned IDLE_THRESH = 4;
  localparam int unsigned WAKE_HOLD   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, data_empty = 1'b1, data_full = 1'b0, force_on = 1'b0;
  logic [11:0] wr_instr = '0;
  logic        fifo_wr_en, fifo_rd_en, clock_disable, stall;
  logic [1:0]  gate_state;
  logic [15:0] gated_cycles;
  logic        w4_fifo_wr_en, w4_fifo_rd_en, w4_clock_disable, w4_stall;
  logic [1:0]  w4_gate_state;
  logic [3:0]  w4_gated_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: consecutive idle cycles, gated flag, remaining wake cycles, total gated cycles.
  int     m_idle  = 0;
  bit     m_gated = 1'b0;
  int     m_wake  = 0;
  longint m_total = 0;
  bit     m_valid = 1'b0;

  always #5 clk = ~clk;

  clk_gate_ctrl u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_en         (wr_en),
    .i_rd_en         (rd_en),
    .i_data_empty    (data_empty),
    .i_data_full     (data_full),
    .i_force_on      (force_on),
    .o_fifo_wr_en    (fifo_wr_en),
    .o_fifo_rd_en    (fifo_rd_en),
    .o_clock_disable (clock_disable),
    .o_stall         (stall),
    .o_gate_state    (gate_state),
    .o_gated_cycles  (gated_cycles)
  );

  clk_gate_ctrl #(
    .CNT_W (4)
  ) u_dut_w4 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_en         (wr_en),
    .i_rd_en         (rd_en),
    .i_data_empty    (data_empty),
    .i_data_full     (data_full),
    .i_force_on      (force_on),
    .o_fifo_wr_en    (w4_fifo_wr_en),
    .o_fifo_rd_en    (w4_fifo_rd_en),
    .o_clock_disable (w4_clock_disable),
    .o_stall         (w4_stall),
    .o_gate_state    (w4_gate_state),
    .o_gated_cycles  (w4_gated_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_stall();
    return m_gated || (m_wake > 0);
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_gated)    return 2'b10;
    if (m_wake > 0) return 2'b11;
    if (m_idle > 0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_check();
    longint sat16, sat4;
    if (!m_valid) return;
    sat16 = (m_total > 65535) ? 65535 : m_total;
    sat4  = (m_total > 15) ? 15 : m_total;
    check_eq("gate_state", {30'd0, gate_state}, {30'd0, exp_state()});
    check_eq("clock_disable", {31'd0, clock_disable}, {31'd0, m_gated});
    check_eq("stall", {31'd0, stall}, {31'd0, exp_stall()});
    check_eq("fifo_wr_en", {31'd0, fifo_wr_en}, {31'd0, wr_en & ~exp_stall() & ~data_full});
    check_eq("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, rd_en & ~exp_stall() & ~data_empty});
    check_eq("gated_cycles", {16'd0, gated_cycles}, 32'(sat16));
    check_eq("gated_cycles_w4", {28'd0, w4_gated_cycles}, 32'(sat4));
  endtask

  task automatic model_update();
    bit act;
    act = (wr_en & ~data_full) | (rd_en & ~data_empty) | force_on;
    if (!rst) begin
      m_idle = 0; m_gated = 0; m_wake = 0; m_total = 0; m_valid = 1;
    end else if (m_gated) begin
      m_total++;
      if (wr_en || rd_en || force_on) begin
        m_gated = 0;
        m_wake  = WAKE_HOLD;
      end
    end else if (m_wake > 0) begin
      m_wake--;
    end else if (act) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == IDLE_THRESH) begin
        m_gated = 1;
        m_idle  = 0;
      end
    end
  endtask

  // Inputs are already driven; check, clock once, advance the model, return at negedge.
  task automatic step();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic w, input logic r, input logic e, input logic f, input logic fo);
    wr_en = w; rd_en = r; data_empty = e; data_full = f; force_on = fo;
  endtask

  task automatic do_reset();
    drive(0, 0, 1, 0, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    bit pend_wr, pend_rd;
    int quiet;
    @(negedge clk);
    do_reset();
    check_eq("reset_state", {30'd0, gate_state}, 32'd0);

    // Idle gating and gated-cycle count.
    step();
    check_eq("drain_after_1", {30'd0, gate_state}, 32'd1);
    steps(3);
    check_eq("gated_after_4", {31'd0, clock_disable}, 32'd1);
    steps(5);
    check_eq("gated_cnt_5", {16'd0, gated_cycles}, 32'd5);

    // Wake by write with a held request.
    wr_instr = 12'b000111111100;
    drive(1, 0, 1, 0, 0);
    step();
    check_eq("wake_state", {30'd0, gate_state}, 32'd3);
    check_eq("wake_clk_on", {31'd0, clock_disable}, 32'd0);
    check_eq("wake_stall1", {31'd0, stall}, 32'd1);
    step();
    check_eq("wake_stall2", {31'd0, stall}, 32'd1);
    step();
    check_eq("wake_run", {30'd0, gate_state}, 32'd0);
    check_eq("wake_wr_go", {31'd0, fifo_wr_en}, 32'd1);
    drive(0, 0, 1, 0, 0);
    step();

    // Idle run interrupted by a real read.
    do_reset();
    steps(3);
    drive(0, 1, 0, 0, 0);
    step();
    check_eq("interrupt_run", {30'd0, gate_state}, 32'd0);
    drive(0, 0, 1, 0, 0);
    steps(3);
    check_eq("no_gate_at_3", {31'd0, clock_disable}, 32'd0);
    step();
    check_eq("gate_at_4", {31'd0, clock_disable}, 32'd1);

    // Writes to a full FIFO and reads from an empty FIFO are idle.
    do_reset();
    drive(1, 0, 1, 1, 0);
    #1 check_eq("full_wr_blocked", {31'd0, fifo_wr_en}, 32'd0);
    steps(4);
    check_eq("full_wr_gates", {31'd0, clock_disable}, 32'd1);
    do_reset();
    drive(0, 1, 1, 0, 0);
    #1 check_eq("empty_rd_blocked", {31'd0, fifo_rd_en}, 32'd0);
    step();

    // Override from DRAIN, then saturation on the narrow counter.
    do_reset();
    steps(2);
    drive(0, 0, 1, 0, 1);
    step();
    check_eq("force_run", {30'd0, gate_state}, 32'd0);
    steps(6);
    check_eq("force_hold", {31'd0, clock_disable}, 32'd0);
    drive(0, 0, 1, 0, 0);
    steps(4 + 20);
    check_eq("sat_15", {28'd0, w4_gated_cycles}, 32'd15);
    steps(3);
    check_eq("sat_hold", {28'd0, w4_gated_cycles}, 32'd15);

    // Reset while gated.
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_eq("rst_gated_state", {30'd0, gate_state}, 32'd0);
    check_eq("rst_gated_clk", {31'd0, clock_disable}, 32'd0);
    check_eq("rst_gated_cnt", {16'd0, gated_cycles}, 32'd0);
    check_eq("rst_gated_stall", {31'd0, stall}, 32'd0);

    // Random traffic; requesters hold their enable until they see stall low.
    pend_wr = 0; pend_rd = 0; quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (quiet == 0 && $urandom_range(0, 9) == 0) quiet = $urandom_range(2, 12);
      rst        = ($urandom_range(0, 299) != 0);
      data_empty = ($urandom_range(0, 3) == 0);
      data_full  = ($urandom_range(0, 3) == 0);
      force_on   = (quiet == 0) && ($urandom_range(0, 19) == 0);
      wr_en      = pend_wr || ((quiet == 0) && ($urandom_range(0, 2) == 0));
      rd_en      = pend_rd || ((quiet == 0) && ($urandom_range(0, 2) == 0));
      wr_instr   = 12'($urandom);
      if (quiet > 0) quiet--;
      pend_wr = wr_en && exp_stall() && rst;
      pend_rd = rd_en && exp_stall() && rst;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Upstream control stage for the instruction-FIFO/ALU combination block.
- Watches FIFO read/write traffic and status, and drives that block's clock_disable input after a run of idle cycles.
- Wakes the clock on new traffic and stalls the producer while the clock is off or restarting.
- Qualifies wr_en/rd_en so that no FIFO access is issued while the clock is disabled.

Parameters:
- IDLE_THRESH, 4: consecutive idle cycles needed before gating; legal range 2..255.
- WAKE_HOLD, 2: cycles spent in WAKE, with the clock enabled and requests still stalled, before returning to RUN; legal range 1..15.
- CNT_W, 16: width of the gated-cycle statistics counter.

Ports:
- clk  in  1  system clock; ungated, free-running.
- rst  in  1  synchronous reset, active-low.
- wr_en  in  1  producer write request, 12-bit instruction.
- rd_en  in  1  consumer read request.
- data_empty  in  1  FIFO empty flag.
- data_full  in  1  FIFO full flag.
- force_on  in  1  debug override; keeps the clock enabled.
- fifo_wr_en  out  1  qualified write enable to the FIFO.
- fifo_rd_en  out  1  qualified read enable to the FIFO.
- clock_disable  out  1  to the combination block's clock gate; 1 = clock off.
- stall  out  1  producer/consumer must hold their requests while this is 1.
- gate_state  out  2  current state: 00 RUN, 01 DRAIN, 10 GATED, 11 WAKE.
- gated_cycles  out  CNT_W  saturating count of cycles spent in GATED.

Behaviour:
- Reset (rst=0 at a clk edge) sets:
  - state RUN, idle_cnt 0, wake_cnt 0, gated_cycles 0;
  - clock_disable 0, stall 0.
  - Reset overrides everything, including mid-GATED; the clock is re-enabled on the next edge.
- Activity per cycle: act = (wr_en & ~data_full) | (rd_en & ~data_empty) | force_on.
  - A write to a full FIFO counts as idle.
  - A read from an empty FIFO counts as idle.
- Outputs:
  - clock_disable = (state==GATED), registered.
  - stall = (state==GATED) | (state==WAKE).
  - fifo_wr_en = wr_en & ~stall & ~data_full.
  - fifo_rd_en = rd_en & ~stall & ~data_empty.
- RUN:
  - act=1: stay in RUN.
  - act=0: go to DRAIN with idle_cnt=1.
- DRAIN:
  - act=1: go to RUN, idle_cnt=0.
  - act=0 and idle_cnt==IDLE_THRESH-1: go to GATED.
  - Otherwise: idle_cnt+1.
  - Result: clock_disable rises on the edge that samples the IDLE_THRESH-th consecutive idle cycle.
- GATED:
  - gated_cycles increments each cycle and saturates at all-ones.
  - Wake condition is wr_en | rd_en | force_on, using raw requests rather than full/empty. The FIFO status is stale while the clock is off, so it is not trusted.
  - On wake: go to WAKE with wake_cnt=0; clock_disable falls on that same edge.
- WAKE:
  - Clock is enabled; requests remain stalled; wake_cnt+1 each cycle.
  - When wake_cnt==WAKE_HOLD-1, go to RUN.
  - Idle detection is suspended in WAKE.
  - The first qualified FIFO access occurs in the first RUN cycle. Wake-to-access latency is therefore WAKE_HOLD+1 edges after the wake request is sampled.
- Simultaneous events:
  - force_on=1 in any state other than WAKE forces RUN on the next edge and clears idle_cnt.
  - force_on from GATED still passes through WAKE.
  - wr_en and rd_en together count as one activity.
- Handshake rule: a requester keeps its enable asserted until it sees stall=0 in the same cycle. No request is dropped or duplicated.
- gated_cycles does not wrap; it holds at 2^CNT_W-1.

Decomposition:
- Package clk_gate_pkg holds the state enum (RUN/DRAIN/GATED/WAKE, 2-bit, encoding as on gate_state) and the default parameter constants.
- One sub-module, sat_counter (width-parameterised, enable, saturating), is used for gated_cycles.
- idle_cnt and wake_cnt stay inline.

Test Plan:
1. Reset mid-GATED: rst=0 for 1 edge while gate_state=10 -> next cycle gate_state=00, clock_disable=0, gated_cycles=0, stall=0.
2. Idle gating with IDLE_THRESH=4: rst released, no requests -> DRAIN after edge 1; clock_disable=1 after edge 4; gated_cycles=5 after 5 further edges.
3. Wake by write, WAKE_HOLD=2:
   - In GATED, hold wr_en=1 with instruction 12'b000111111100.
   - Required: clock_disable=0 and gate_state=11 after 1 edge; stall=1 for 2 cycles; fifo_wr_en=1 in exactly the following cycle only, while wr_en is held.
4. Idle-count interruption:
   - 3 idle cycles, then rd_en=1 with data_empty=0, then idle -> return to RUN, idle_cnt reset.
   - Gating happens only after 4 fresh idle cycles.
5. Boundary qualification:
   - wr_en=1 with data_full=1 in RUN -> fifo_wr_en=0 and counted as idle (gates after 4 cycles).
   - rd_en=1 with data_empty=1 -> fifo_rd_en=0.
6. Override and saturation:
   - force_on=1 in DRAIN -> gate_state=00, no gating while held.
   - CNT_W=4 held in GATED for 20 cycles -> gated_cycles=15 and stays at 15.
